// File: rtl/word_mux_prio_filtered_if.sv
// Bus bundle for the filtered priority word multiplexer: channel data, select
// requests and enable in; registered word, active index and status flags out.
interface word_mux_prio_filtered_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  localparam int IDX_W   = $clog2(CHANNELS)
);
  logic [CHANNELS*WIDTH-1:0] Data_i;
  logic [CHANNELS-1:0]       Sel_i;
  logic                      Enable_i;
  logic [WIDTH-1:0]          Y_o;
  logic [IDX_W-1:0]          SelIdx_o;
  logic                      Switched_o;
  logic                      Pending_o;

  // The multiplexer consumes inputs every enabled cycle; there is no back-pressure.
  modport slave (
    input  Data_i, Sel_i, Enable_i,
    output Y_o, SelIdx_o, Switched_o, Pending_o
  );

  modport master (
    output Data_i, Sel_i, Enable_i,
    input  Y_o, SelIdx_o, Switched_o, Pending_o
  );
endinterface

// File: rtl/word_mux_prio_filtered.sv
// N-channel priority word multiplexer with a registered output; a new select
// request only takes effect after FILTER_CYCLES consecutive enabled cycles.
module word_mux_prio_filtered #(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 8,
  parameter int FILTER_CYCLES = 3,
  localparam int IDX_W        = $clog2(CHANNELS),
  localparam int CNT_W        = $clog2(FILTER_CYCLES + 1)
) (
  input  logic                      Clk_i,
  input  logic                      Reset_i,
  word_mux_prio_filtered_if.slave   bus_if
);

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] active_q, active_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             sw_q, sw_d;
  logic [WIDTH-1:0] chan_data [CHANNELS];

  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      chan_data[k] = bus_if.Data_i[k*WIDTH +: WIDTH];
    end
  end

  // Highest requesting channel wins; bit 0 is never a request of its own.
  always_comb begin
    req_idx = '0;
    for (int k = 1; k < CHANNELS; k++) begin
      if (bus_if.Sel_i[k]) req_idx = IDX_W'(k);
    end
  end

  always_comb begin
    active_d = active_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    sw_d     = 1'b0;
    y_d      = y_q;
    if (bus_if.Enable_i) begin
      if (req_idx == active_q) begin
        cnt_d = '0;
      end else if (req_idx != cand_q || cnt_q == '0) begin
        cand_d = req_idx;
        if (FILTER_CYCLES == 1) begin
          active_d = req_idx;
          sw_d     = 1'b1;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end else if (cnt_q + CNT_W'(1) == CNT_W'(FILTER_CYCLES)) begin
        active_d = req_idx;
        cnt_d    = '0;
        sw_d     = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Output follows the post-edge active channel so data and strobe align.
      y_d = chan_data[active_d];
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      active_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      sw_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      sw_q     <= sw_d;
    end
  end

  assign bus_if.Y_o        = y_q;
  assign bus_if.SelIdx_o   = active_q;
  assign bus_if.Switched_o = sw_q;
  assign bus_if.Pending_o  = (cnt_q != '0);

endmodule

// File: tb/tb_word_mux_prio_filtered.sv
// Bench for word_mux_prio_filtered: directed scenarios plus randomized traffic,
// every cycle checked against a streak-counting reference model.
module tb_word_mux_prio_filtered;
  localparam int CH = 4;
  localparam int W  = 8;
  localparam int FC = 3;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Reference model state
  int         m_a;
  int         m_streak_val;
  int         m_len;
  logic [7:0] m_y;
  logic       m_sw;

  word_mux_prio_filtered_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  word_mux_prio_filtered #(.CHANNELS(CH), .WIDTH(W), .FILTER_CYCLES(FC)) dut (
    .Clk_i   (clk),
    .Reset_i (rst),
    .bus_if  (bus)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int req_of(input logic [3:0] s);
    int r;
    r = 0;
    if (s[1]) r = 1;
    if (s[2]) r = 2;
    if (s[3]) r = 3;
    return r;
  endfunction

  function automatic logic [7:0] chan(input logic [31:0] d, input int k);
    logic [31:0] t;
    t = d >> (k * 8);
    return t[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance for one clock edge, from the rules on request streaks.
  task automatic model_edge(input logic r_in, input logic en, input logic [3:0] s, input logic [31:0] d);
    int r;
    if (r_in) begin
      m_a = 0; m_streak_val = 0; m_len = 0; m_y = 8'h00; m_sw = 1'b0;
    end else if (!en) begin
      m_sw = 1'b0;
    end else begin
      r    = req_of(s);
      m_sw = 1'b0;
      if (r == m_a) begin
        m_len = 0;
      end else begin
        if (m_len > 0 && r == m_streak_val) m_len = m_len + 1;
        else begin m_streak_val = r; m_len = 1; end
        if (m_len == FC) begin
          m_a = r; m_len = 0; m_sw = 1'b1;
        end
      end
      m_y = chan(d, m_a);
    end
  endtask

  task automatic compare_all();
    check("y",        32'(bus.Y_o),        32'(m_y));
    check("selidx",   32'(bus.SelIdx_o),   32'(m_a));
    check("switched", 32'(bus.Switched_o), 32'(m_sw));
    check("pending",  32'(bus.Pending_o),  32'(m_len != 0));
  endtask

  // driver: apply inputs at the falling edge, advance model at rising edge,
  // compare at the next falling edge.
  task automatic step(input logic r_in, input logic en, input logic [3:0] s, input logic [31:0] d);
    rst          = r_in;
    bus.Enable_i = en;
    bus.Sel_i    = s;
    bus.Data_i   = d;
    @(posedge clk);
    model_edge(r_in, en, s, d);
    @(negedge clk);
    compare_all();
  endtask

  localparam logic [31:0] DFIX = 32'h44332211;

  initial begin
    logic [3:0] sel_r;
    total = 0;
    bad   = 0;
    m_a = 0; m_streak_val = 0; m_len = 0; m_y = '0; m_sw = 1'b0;
    rst = 1'b1; bus.Enable_i = 1'b0; bus.Sel_i = '0; bus.Data_i = DFIX;
    @(negedge clk);

    // 1: reset for two cycles, then release
    step(1'b1, 1'b1, 4'b0000, DFIX);
    step(1'b1, 1'b1, 4'b0000, DFIX);
    check("t1_y_reset", 32'(bus.Y_o), 32'h00);
    step(1'b0, 1'b1, 4'b0000, DFIX);
    check("t1_y", 32'(bus.Y_o), 32'h11);
    check("t1_model_y", 32'(m_y), 32'h11);

    // 2: request channel 2, switch at the third edge
    step(1'b0, 1'b1, 4'b0100, DFIX);
    check("t2_pend1", 32'(bus.Pending_o), 32'd1);
    step(1'b0, 1'b1, 4'b0100, DFIX);
    check("t2_pend2", 32'(bus.Pending_o), 32'd1);
    step(1'b0, 1'b1, 4'b0100, DFIX);
    check("t2_idx", 32'(bus.SelIdx_o), 32'd2);
    check("t2_y", 32'(bus.Y_o), 32'h33);
    check("t2_sw", 32'(bus.Switched_o), 32'd1);
    check("t2_model_sw", 32'(m_sw), 32'd1);
    step(1'b0, 1'b1, 4'b0100, DFIX);
    check("t2_sw_drop", 32'(bus.Switched_o), 32'd0);

    // 3: highest index wins, then back to channel 2
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b1110, DFIX);
    check("t3_y44", 32'(bus.Y_o), 32'h44);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0110, DFIX);
    check("t3_y33", 32'(bus.Y_o), 32'h33);

    // back to channel 0
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'b0000, DFIX);
    check("t4_home", 32'(bus.SelIdx_o), 32'd0);

    // 4: changing requests never complete a streak
    step(1'b0, 1'b1, 4'b0010, DFIX);
    step(1'b0, 1'b1, 4'b0010, DFIX);
    step(1'b0, 1'b1, 4'b0100, DFIX);
    step(1'b0, 1'b1, 4'b0100, DFIX);
    check("t4_pend", 32'(bus.Pending_o), 32'd1);
    step(1'b0, 1'b1, 4'b0000, DFIX);
    check("t4_pend_drop", 32'(bus.Pending_o), 32'd0);
    check("t4_y", 32'(bus.Y_o), 32'h11);

    // 5: disabled cycles neither count nor break the streak
    step(1'b0, 1'b1, 4'b0010, DFIX);
    step(1'b0, 1'b0, 4'b0010, 32'hAABBCCDD);
    check("t5_hold_y", 32'(bus.Y_o), 32'h11);
    check("t5_hold_pend", 32'(bus.Pending_o), 32'd1);
    step(1'b0, 1'b0, 4'b0010, DFIX);
    step(1'b0, 1'b1, 4'b0010, DFIX);
    check("t5_no_sw_yet", 32'(bus.SelIdx_o), 32'd0);
    step(1'b0, 1'b1, 4'b0010, DFIX);
    check("t5_idx", 32'(bus.SelIdx_o), 32'd1);
    check("t5_y", 32'(bus.Y_o), 32'h22);

    // 6: reset aborts a pending count
    step(1'b0, 1'b1, 4'b0100, DFIX);
    step(1'b0, 1'b1, 4'b0100, DFIX);
    check("t6_pend", 32'(bus.Pending_o), 32'd1);
    step(1'b1, 1'b1, 4'b0100, DFIX);
    check("t6_idx", 32'(bus.SelIdx_o), 32'd0);
    check("t6_y", 32'(bus.Y_o), 32'h00);
    check("t6_pend0", 32'(bus.Pending_o), 32'd0);
    step(1'b0, 1'b1, 4'b0000, DFIX);
    check("t6_y_after", 32'(bus.Y_o), 32'h11);

    // randomized traffic; sticky selects so streaks actually complete
    sel_r = 4'(($urandom_range(0, 15)));
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) sel_r = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8), sel_r, $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
